// File: rtl/serial_pkg.sv
// Shared types and helpers for the bit-serial transmit/receive pair.
package serial_pkg;

  typedef enum logic {IDLE, SHIFT} ser_state_t;

  localparam int unsigned DEFAULT_DATA_WIDTH = 32;
  localparam int unsigned CNT_W              = $clog2(DEFAULT_DATA_WIDTH);
  // Widest word bit_reverse can handle; callers zero-extend into it.
  localparam int unsigned SER_MAX_W          = 64;

  // Reverse the low 'width' bits of word; bits at or above 'width' return 0.
  function automatic logic [SER_MAX_W-1:0] bit_reverse(input logic [SER_MAX_W-1:0] word,
                                                       input int unsigned          width);
    logic [SER_MAX_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < SER_MAX_W; i++) begin
      if (i < width) r[i] = word[width-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_reverse_tx_bit_counter.sv
// Modulo-WIDTH bit counter with clear and enable; flags the last bit position.
module ser_bit_counter
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic is_last_c
);

  localparam int unsigned CNT_BITS = $clog2(WIDTH);

  logic [CNT_BITS-1:0] cnt_q, cnt_d;

  assign is_last_c = (cnt_q == CNT_BITS'(WIDTH - 1));

  // Clear wins over enable; wraps to zero after the last position.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = is_last_c ? '0 : cnt_q + CNT_BITS'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/serial_reverse_tx.sv
// Word-to-bit serializer with per-word bit order and valid/ready on both sides.
module serial_reverse_tx
  import serial_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  output logic                  din_ready,
  input  logic                  msb_first,
  output logic                  dout,
  output logic                  dout_valid,
  output logic                  dout_last,
  input  logic                  dout_ready
);

  ser_state_t            state_q, state_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic                  is_last;
  logic                  beat;
  logic                  load;

  ser_bit_counter #(.WIDTH(DATA_WIDTH)) u_cnt (
    .clk       (clk),
    .reset     (reset),
    .clr       (load),
    .en        (beat),
    .is_last_c (is_last)
  );

  assign dout       = shreg_q[0];
  assign dout_valid = (state_q == SHIFT);
  assign dout_last  = dout_valid && is_last;

  // Next state, shift path and handshake; a load on the last beat keeps SHIFT.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    beat      = dout_valid && dout_ready;
    din_ready = (state_q == IDLE) || (dout_last && dout_ready);
    load      = din_valid && din_ready;

    if (beat) begin
      shreg_d = shreg_q >> 1;
      if (is_last) state_d = IDLE;
    end

    if (load) begin
      shreg_d = msb_first ? DATA_WIDTH'(bit_reverse(SER_MAX_W'(din), DATA_WIDTH)) : din;
      state_d = SHIFT;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
    end
  end

endmodule

// File: tb/tb_serial_reverse_tx.sv
// Self-checking bench for serial_reverse_tx at DATA_WIDTH=8 using a bit-queue model.
module tb_serial_reverse_tx;

  localparam int unsigned W = 8;

  typedef struct {
    logic b;
    logic l;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] din;
  logic         din_valid;
  logic         din_ready;
  logic         msb_first;
  logic         dout;
  logic         dout_valid;
  logic         dout_last;
  logic         dout_ready;

  int total = 0;
  int bad   = 0;

  exp_t         q[$];
  logic [W-1:0] wq[$];
  logic         mq[$];

  always #5 clk = ~clk;

  serial_reverse_tx #(.DATA_WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .msb_first  (msb_first),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_last  (dout_last),
    .dout_ready (dout_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [W-1:0] w, input logic m);
    wq.push_back(w);
    mq.push_back(m);
  endtask

  // Expected serial stream of one word: position i carries w[i] (LSB-first) or w[W-1-i].
  task automatic expand(input logic [W-1:0] w, input logic m);
    for (int i = 0; i < W; i++) begin
      exp_t e;
      e.b = m ? w[W-1-i] : w[i];
      e.l = (i == W - 1);
      q.push_back(e);
    end
  endtask

  // mode 0: sink always ready; 1: random ready; 2: 3-cycle stall while bit 3 is shown.
  task automatic run_stream(input int mode, input bit b2b, input int stop_beats);
    int   beats = 0;
    int   cyc   = 0;
    int   stall = 0;
    logic exp_ready;
    while ((wq.size() != 0 || q.size() != 0) && !(stop_beats != 0 && beats >= stop_beats)) begin
      if (cyc >= 2000) begin
        total++;
        bad++;
        $error("FAIL timeout observed=%0d expected<2000 cycles", cyc);
        break;
      end
      @(negedge clk);
      din_valid = (wq.size() != 0) && (b2b || q.size() == 0);
      din       = (wq.size() != 0) ? wq[0] : '0;
      msb_first = (mq.size() != 0) ? mq[0] : 1'b0;
      case (mode)
        1:       dout_ready = ($urandom_range(0, 3) != 0);
        2: begin
          if (beats == 2 && stall < 3) begin
            dout_ready = 1'b0;
            stall++;
          end else begin
            dout_ready = 1'b1;
          end
        end
        default: dout_ready = 1'b1;
      endcase
      #1;
      exp_ready = (q.size() == 0) || (q.size() == 1 && dout_ready);
      chk("dout_valid", 32'(dout_valid), 32'(q.size() != 0));
      if (q.size() != 0) begin
        chk("dout", 32'(dout), 32'(q[0].b));
        chk("dout_last", 32'(dout_last), 32'(q[0].l));
      end else begin
        chk("idle_dout_last", 32'(dout_last), 32'(0));
      end
      chk("din_ready", 32'(din_ready), 32'(exp_ready));
      @(posedge clk);
      if (q.size() != 0 && dout_ready) begin
        void'(q.pop_front());
        beats++;
      end
      if (din_valid && exp_ready) begin
        expand(wq.pop_front(), mq.pop_front());
      end
      cyc++;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_dout"}, 32'(dout), 32'(0));
    chk({tag, "_dout_valid"}, 32'(dout_valid), 32'(0));
    chk({tag, "_dout_last"}, 32'(dout_last), 32'(0));
    chk({tag, "_din_ready"}, 32'(din_ready), 32'(1));
  endtask

  initial begin
    reset      = 1'b1;
    din        = '0;
    din_valid  = 1'b0;
    msb_first  = 1'b0;
    dout_ready = 1'b0;
    #1;
    chk_reset_outputs("in_reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk_reset_outputs("after_reset");

    // LSB-first and MSB-first of 0xB4
    push_word(8'hB4, 1'b0);
    run_stream(0, 1'b0, 0);
    push_word(8'hB4, 1'b1);
    run_stream(0, 1'b0, 0);

    // Back-to-back words, din_valid held
    push_word(8'h01, 1'b0);
    push_word(8'h80, 1'b0);
    run_stream(0, 1'b1, 0);

    // Backpressure stall
    push_word(8'hB4, 1'b0);
    run_stream(2, 1'b0, 0);

    // Reset after 4 bits of 0xFF
    push_word(8'hFF, 1'b0);
    run_stream(0, 1'b0, 4);
    @(negedge clk);
    din_valid = 1'b0;
    reset     = 1'b1;
    #1;
    chk_reset_outputs("mid_reset");
    q.delete();
    @(negedge clk);
    reset = 1'b0;
    push_word(8'h0F, 1'b1);
    run_stream(0, 1'b0, 0);

    // Random words, orders, sink stalls and source pacing
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < 5; k++) begin
        push_word(W'($urandom), 1'($urandom_range(0, 1)));
      end
      run_stream(1, 1'($urandom_range(0, 1)), 0);
    end

    @(negedge clk);
    dout_ready = 1'b1;
    #1;
    chk_reset_outputs("final_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_reverse_tx.md
# serial_reverse_tx

Parallel-to-serial transmitter that takes one DATA_WIDTH-bit word through a valid/ready handshake and shifts it out one bit per accepted beat. The bit order is selectable per word, so the serial stream carries either the word itself (MSB-first) or its bit reversal (LSB-first). It sits after word-level datapaths and feeds bit-serial links; the matching deserializer on the far end rebuilds the word.

## Interface
- DATA_WIDTH, 32, bits per word; must be at least 2.

- clk  input  1  rising-edge clock; the block's only clock.
- reset  input  1  asynchronous, active-high reset.
- din  input  DATA_WIDTH  word to transmit.
- din_valid  input  1  din is valid this cycle.
- din_ready  output  1  block can accept a word this cycle.
- msb_first  input  1  bit order, sampled with the word: 1 sends din[DATA_WIDTH-1] first, 0 sends din[0] first.
- dout  output  1  current serial bit.
- dout_valid  output  1  dout is valid.
- dout_last  output  1  dout is the final bit of the word.
- dout_ready  input  1  sink accepts dout this cycle.

## Operation
- FSM with two states:
  - IDLE: no word loaded.
  - SHIFT: word in flight.
- Load happens when din_valid && din_ready:
  - Shift register shreg is loaded with din if msb_first=0, or with bit-reversed din if msb_first=1.
  - Bit counter cnt is cleared.
  - State goes to SHIFT.
- SHIFT outputs: dout = shreg[0], dout_valid = 1, dout_last = (cnt == DATA_WIDTH-1).
- Beat: dout_valid && dout_ready.
  - On a beat, shreg shifts right by one (0 enters the MSB) and cnt increments.
  - On the last beat, cnt clears and state returns to IDLE, unless a new load happens in the same cycle. In that case state stays SHIFT with the new word loaded.
- din_ready = (state==IDLE) || (state==SHIFT && dout_last && dout_ready). It is combinational, which allows back-to-back words.
- msb_first and din are only sampled at load. Later changes have no effect on the word in flight.
- Backpressure: while dout_valid && !dout_ready, dout, dout_last, shreg and cnt all hold.
- cnt width is $clog2(DATA_WIDTH). cnt never exceeds DATA_WIDTH-1.
- din_valid without din_ready: the word is not taken. The source must hold it.

## Timing
- Reset (asynchronous assert, synchronous-safe release):
  - State goes to IDLE.
  - shreg = 0, cnt = 0.
  - dout = 0, dout_valid = 0, dout_last = 0.
  - din_ready = 1, because it is derived from state. din_valid must be low while reset is high.
- Latency: a word accepted at edge k presents its first bit, with dout_valid=1, in the cycle after edge k.
- Throughput: with dout_ready held at 1 and din_valid held at 1, the block produces one bit per cycle with no bubbles between words. That is one word per DATA_WIDTH cycles.
- Reset mid-word: the word is discarded immediately and no partial-word completion occurs. The next accepted word starts at its first bit.
- dout_last is high for exactly one beat per word.

## Structure
- Shared package serial_pkg contains:
  - typedef enum logic {IDLE, SHIFT} ser_state_t.
  - Function bit_reverse(word) for the load path. This is the single source of bit reversal, shared with the deserializer.
  - Helper constant CNT_W = $clog2(DATA_WIDTH).
- Sub-module ser_bit_counter: modulo-DATA_WIDTH counter with clear, enable and an is_last output. It is reused by the receive side.
- Top level holds the FSM, shreg and the handshake logic.

## Test plan
All scenarios use DATA_WIDTH=8.
- Reset, then idle: dout_valid=0, dout=0, dout_last=0, din_ready=1.
- LSB-first order: din=0xB4, msb_first=0, dout_ready=1. Bits are 0,0,1,0,1,1,0,1 on 8 consecutive cycles, with dout_last only on the 8th. din_ready returns to 1 on the last beat.
- MSB-first order: din=0xB4, msb_first=1. Bits are 1,0,1,1,0,1,0,0.
- Back-to-back words: 0x01 then 0x80, msb_first=0, din_valid held high. Output is 1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,1 over 16 contiguous valid cycles, with dout_last on cycles 8 and 16.
- Backpressure: din=0xB4, msb_first=0. dout_ready is dropped for 3 cycles after the 3rd bit. dout holds 1 and dout_valid holds 1 through the stall, and the full sequence still matches 0,0,1,0,1,1,0,1.
- Reset mid-word: reset is asserted after 4 bits of 0xFF. Outputs go to reset values in the same cycle. The next word, 0x0F with msb_first=1, emits 0,0,0,0,1,1,1,1.
